// File: rtl/pll_reset_ctrl.sv
// PLL areset/lock sequencer with stretched system reset; PLL_LOSS_RELOCK_EN re-resets the PLL on lock loss.
// Outputs registered from next state (change on the transition edge); no backpressure, i_restart always wins.
module pll_reset_ctrl #(
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 1024,
    parameter int RELEASE_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    input  logic       i_restart,
    output logic       o_pll_areset,
    output logic       o_rst,
    output logic       o_ready,
    output logic [7:0] o_retries,
    output logic [7:0] o_losses
);

    localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE > RELEASE_CYCLES) ? LOCK_STABLE : RELEASE_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] RC_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] RL_LAST  = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

`ifdef PLL_LOSS_RELOCK_EN
    localparam state_t LOSS_TARGET = PLL_RST;
`else
    localparam state_t LOSS_TARGET = WAIT_LOCK;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, sync1_d;
    logic            lock_s_q, lock_s_d;
    logic            areset_q, areset_d;
    logic            rst_q, rst_d;
    logic            ready_q, ready_d;
    logic [7:0]      retries_q, retries_d;
    logic [7:0]      losses_q, losses_d;

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        losses_d  = losses_q;
        sync1_d   = i_locked;
        lock_s_d  = sync1_q;

        if (i_restart) begin
            state_d = PLL_RST;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RC_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = STABLE;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = PLL_RST;
                        if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
                    end
                end
                STABLE: begin
                    if (!lock_s_q)              state_d = WAIT_LOCK;
                    else if (cnt_q == ST_LAST)  state_d = RELEASE;
                end
                RELEASE: begin
                    if (!lock_s_q) begin
                        state_d = LOSS_TARGET;
                        if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
                    end else if (cnt_q == RL_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_d = LOSS_TARGET;
                        if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
                    end
                end
                default: state_d = PLL_RST;
            endcase
        end

        // Restart clears the counter even when already in PLL_RST
        cnt_d    = (i_restart || (state_d != state_q)) ? '0 : cnt_q + CNT_ONE;
        areset_d = (state_d == PLL_RST);
        rst_d    = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            areset_q  <= 1'b1;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
            retries_q <= 8'd0;
            losses_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= sync1_d;
            lock_s_q  <= lock_s_d;
            areset_q  <= areset_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            retries_q <= retries_d;
            losses_q  <= losses_d;
        end
    end

    assign o_pll_areset = areset_q;
    assign o_rst        = rst_q;
    assign o_ready      = ready_q;
    assign o_retries    = retries_q;
    assign o_losses     = losses_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: elapsed-time model checked every cycle plus hand-computed timing points.
module tb_pll_reset_ctrl;

    localparam int RC = 4;
    localparam int TO = 16;
    localparam int ST = 8;
    localparam int RL = 4;

    localparam int P_AR   = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;

`ifdef PLL_LOSS_RELOCK_EN
    localparam int LOSS_PHASE = P_AR;
`else
    localparam int LOSS_PHASE = P_WAIT;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       locked  = 1'b0;
    logic       restart = 1'b0;
    logic       areset, orst, ready;
    logic [7:0] retries, losses;

    int checks = 0;
    int errors = 0;

    pll_reset_ctrl #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (TO),
        .LOCK_STABLE   (ST),
        .RELEASE_CYCLES(RL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_locked    (locked),
        .i_restart   (restart),
        .o_pll_areset(areset),
        .o_rst       (orst),
        .o_ready     (ready),
        .o_retries   (retries),
        .o_losses    (losses)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus the edge on which it was entered; lock seen by the
    // sequencer is i_locked as sampled two edges earlier.
    int m_phase = P_AR;
    int m_edge  = 0;
    int m_entry = 0;
    int m_ret   = 0;
    int m_loss  = 0;
    bit m_seen1 = 1'b0;
    bit m_seen2 = 1'b0;
    int m_el;
    int m_nxt;
    bit m_ls;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = P_AR;
            m_edge  = 0;
            m_entry = 0;
            m_ret   = 0;
            m_loss  = 0;
            m_seen1 = 1'b0;
            m_seen2 = 1'b0;
        end else begin
            m_edge  = m_edge + 1;
            m_el    = m_edge - m_entry - 1;
            m_ls    = m_seen2;
            m_seen2 = m_seen1;
            m_seen1 = locked;
            m_nxt   = m_phase;
            if (restart) begin
                m_nxt = P_AR;
            end else if (m_phase == P_AR) begin
                if (m_el == RC - 1) m_nxt = P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if (m_ls) m_nxt = P_STAB;
                else if (m_el == TO - 1) begin
                    m_nxt = P_AR;
                    if (m_ret < 255) m_ret = m_ret + 1;
                end
            end else if (m_phase == P_STAB) begin
                if (!m_ls) m_nxt = P_WAIT;
                else if (m_el == ST - 1) m_nxt = P_REL;
            end else begin
                if (!m_ls) begin
                    m_nxt = LOSS_PHASE;
                    if (m_loss < 255) m_loss = m_loss + 1;
                end else if (m_phase == P_REL && m_el == RL - 1) begin
                    m_nxt = P_RUN;
                end
            end
            if (restart || m_nxt != m_phase) begin
                m_phase = m_nxt;
                m_entry = m_edge;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("areset", areset, (m_phase == P_AR) ? 1 : 0);
        check("rst",    orst,   (m_phase != P_RUN) ? 1 : 0);
        check("ready",  ready,  (m_phase == P_RUN) ? 1 : 0);
        check("retries", retries, m_ret);
        check("losses",  losses,  m_loss);
    end

    // Counts posedges (first one counted as 1) until o_rst equals want.
    task automatic edges_until_rst(input logic want, input int bound, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (orst != want && k < bound);
    endtask

    int n, k, e;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_areset",  areset,  1);
        check("reset_rst",     orst,    1);
        check("reset_ready",   ready,   0);
        check("reset_retries", retries, 0);
        check("reset_losses",  losses,  0);
        repeat (3) @(negedge clk);

        // Normal lock
        rst = 1'b0;
        n = 0;
        while (areset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("areset_width", n, 4);
        @(negedge clk);
        locked = 1'b1;
        edges_until_rst(1'b0, 60, k);
        check("lock_to_release", k - 1, 14);
        check("run_ready", ready, 1);
        check("run_retries", retries, 0);

        // Loss in RUN
        @(negedge clk);
        locked = 1'b0;
        edges_until_rst(1'b1, 20, k);
        check("loss_latency", k, 3);
        check("loss_ready", ready, 0);
        check("loss_count", losses, 1);
`ifdef PLL_LOSS_RELOCK_EN
        check("loss_areset", areset, 1);
`else
        check("loss_areset", areset, 0);
`endif
        repeat (6) @(negedge clk);
        locked = 1'b1;
        edges_until_rst(1'b0, 60, k);
        check("relock_to_release", k - 1, 14);

        // Restart from RUN
        @(negedge clk);
        restart = 1'b1;
        locked  = 1'b0;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("restart_areset", areset, 1);
        check("restart_rst", orst, 1);
        check("restart_ready", ready, 0);
        check("restart_retries", retries, 0);
        check("restart_losses", losses, 1);

        // Glitchy lock
        n = 0;
        while (areset && n < 50) begin
            @(negedge clk);
            n++;
        end
        locked = 1'b1;
        repeat (5) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        edges_until_rst(1'b0, 60, k);
        check("glitch_to_release", k - 1, 14);

        // Asynchronous reset while in STABLE
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n = 0;
        while (areset && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("stable_areset_low", areset, 0);
        #2 rst = 1'b1;
        #1;
        check("async_areset",  areset,  1);
        check("async_rst",     orst,    1);
        check("async_ready",   ready,   0);
        check("async_retries", retries, 0);
        check("async_losses",  losses,  0);
        locked = 1'b0;
        repeat (2) @(negedge clk);

        // No lock: a timeout every RC+TO edges
        rst = 1'b0;
        e = 0;
        for (int t = 1; t <= 3; t++) begin
            do begin
                @(posedge clk);
                #1;
                e++;
            end while (retries != 8'(t) && e < 200);
            check("retry_edge", e, 20 * t);
            check("retry_count", retries, t);
            check("retry_rst_held", orst, 1);
        end

        // Saturation
        repeat (300 * 20) @(negedge clk);
        check("retries_saturated", retries, 255);
        repeat (25) @(negedge clk);
        check("retries_no_wrap", retries, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
